// File: rtl/rejestry_pkg.sv
// rejestry_pkg: shared constants and types for the general-purpose register bank.
//   DATA_W        - register width in bits
//   RX_LICZBA_DEF - default number of registers in the bank
//   dane_t        - one register word
package rejestry_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned RX_LICZBA_DEF = 8;

  typedef logic [DATA_W-1:0] dane_t;

endpackage : rejestry_pkg

// File: rtl/rejestry_bank_cell.sv
// rejestr_cell: a single register word with asynchronous active-low clear and a load enable.
// Ports:
//   clk_i  - clock, loads on the rising edge
//   rst_ni - asynchronous active-low clear (word goes to zero immediately)
//   ld_i   - load enable; when high, d_i is captured on the rising edge
//   d_i    - data to load
//   q_o    - stored word
module rejestr_cell
  import rejestry_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  ld_i,
  input  dane_t d_i,
  output dane_t q_o
);

  dane_t val_d;
  dane_t val_q;

  always_comb begin
    val_d = val_q;
    if (ld_i) begin
      val_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q_o = val_q;

endmodule : rejestr_cell

// File: rtl/rejestry_bank.sv
// rejestry_bank: general-purpose register bank of the CPU datapath.
// Holds Rx_liczba words R0..R(Rx_liczba-1). nr_Rx selects one word for both the write and the
// combinational read.
// Ports:
//   clk   - clock; writes happen on the rising edge
//   rst   - asynchronous active-low reset; clears every register immediately
//   wr_Rx - write enable for the register selected by nr_Rx
//   nr_Rx - register index, shared by the write and the read
//   dane  - write data
//   out   - contents of the selected register (zero for an index outside the bank)
// Build option:
//   RX_WRITE_BYPASS_EN - when defined, an in-range write forwards dane to out before the edge.
module rejestry_bank
  import rejestry_pkg::*;
#(
  parameter int unsigned Rx_liczba = RX_LICZBA_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_Rx,
  input  logic [$clog2(Rx_liczba)-1:0] nr_Rx,
  input  logic [DATA_W-1:0]            dane,
  output logic [DATA_W-1:0]            out
);

  localparam int unsigned IdxW = $clog2(Rx_liczba);

  dane_t              cell_q [Rx_liczba];
  logic [Rx_liczba-1:0] cell_we;
  logic               in_range;
  dane_t              out_stored;

  // The index field can encode more values than there are registers when Rx_liczba is not a
  // power of two; those indices neither write nor read anything.
  assign in_range = {{(32-IdxW){1'b0}}, nr_Rx} < Rx_liczba;

  for (genvar g = 0; g < Rx_liczba; g++) begin : g_cell
    // Out-of-range indices never match any g, so no separate range gating is needed here.
    assign cell_we[g] = wr_Rx && (nr_Rx == IdxW'(g));

    rejestr_cell u_cell (
      .clk_i  (clk),
      .rst_ni (rst),
      .ld_i   (cell_we[g]),
      .d_i    (dane),
      .q_o    (cell_q[g])
    );
  end

  always_comb begin
    out_stored = '0;
    for (int i = 0; i < int'(Rx_liczba); i++) begin
      if (nr_Rx == IdxW'(i)) begin
        out_stored = cell_q[i];
      end
    end
  end

`ifdef RX_WRITE_BYPASS_EN
  // Write-through: the word about to be written is visible before the edge. Held off during
  // reset because the write will be discarded.
  always_comb begin
    out = out_stored;
    if (rst && wr_Rx && in_range) begin
      out = dane;
    end
  end
`else
  always_comb begin
    out = out_stored;
    if (!in_range) begin
      out = '0;
    end
  end
`endif

endmodule : rejestry_bank

// File: tb/tb_rejestry_bank.sv
// Scoreboard bench for rejestry_bank: an 8-register bank and a 5-register bank (to reach
// out-of-range indices). Stimulus pushes expected words; a monitor pops and compares.
module tb_rejestry_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr8 = 1'b0;
  logic [2:0] nr8 = '0;
  logic [7:0] d8  = '0;
  logic [7:0] out8;
  logic       wr5 = 1'b0;
  logic [2:0] nr5 = '0;
  logic [7:0] d5  = '0;
  logic [7:0] out5;

  always #5 clk = ~clk;

  rejestry_bank #(.Rx_liczba(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .wr_Rx (wr8),
    .nr_Rx (nr8),
    .dane  (d8),
    .out   (out8)
  );

  rejestry_bank #(.Rx_liczba(5)) dut5 (
    .clk   (clk),
    .rst   (rst),
    .wr_Rx (wr5),
    .nr_Rx (nr5),
    .dane  (d5),
    .out   (out5)
  );

  typedef struct {
    int         sel;
    logic [7:0] exp;
    string      name;
  } sb_t;

  sb_t  sb_q[$];
  event chk_ev;
  int   n_vec = 0;
  int   n_err = 0;

`ifdef RX_WRITE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  // Monitor: samples the selected DUT each time the stimulus side raises a check.
  initial begin
    sb_t        e;
    logic [7:0] act;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = (e.sel == 0) ? out8 : out5;
        n_vec++;
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL %s: out=%h expected=%h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic check(input int sel, input logic [7:0] exp, input string name);
    sb_t e;
    #1;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  task automatic write(input int sel, input int idx, input logic [7:0] d);
    @(negedge clk);
    if (sel == 0) begin
      wr8 = 1'b1; nr8 = 3'(idx); d8 = d;
    end else begin
      wr5 = 1'b1; nr5 = 3'(idx); d5 = d;
    end
    @(posedge clk);
    #1;
    wr8 = 1'b0;
    wr5 = 1'b0;
  endtask

  initial begin
    // Reset held with no writes: every index reads zero.
    #20;
    for (int i = 0; i < 8; i++) begin
      nr8 = 3'(i);
      check(0, 8'h00, $sformatf("reset_r%0d", i));
    end
    for (int i = 0; i < 5; i++) begin
      nr5 = 3'(i);
      check(1, 8'h00, $sformatf("reset5_r%0d", i));
    end

    // Write attempted during reset is ignored.
    write(0, 1, 8'hAB);
    nr8 = 3'd1;
    check(0, 8'h00, "wr_in_reset");

    @(negedge clk);
    rst = 1'b1;

    // Single write.
    write(0, 3, 8'hF0);
    nr8 = 3'd3; check(0, 8'hF0, "single_r3");
    nr8 = 3'd2; check(0, 8'h00, "single_r2");
    nr8 = 3'd4; check(0, 8'h00, "single_r4");

    // Before the edge out shows the stored word, or dane with forwarding enabled.
    @(negedge clk);
    wr8 = 1'b1; nr8 = 3'd5; d8 = 8'h3C;
    check(0, Bypass ? 8'h3C : 8'h00, "pre_edge_r5");
    @(posedge clk);
    check(0, 8'h3C, "post_edge_r5");
    wr8 = 1'b0;

    // Hold with wr_Rx low while dane changes.
    nr8 = 3'd3; d8 = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      check(0, 8'hF0, $sformatf("hold_%0d", k));
    end

    // Full sweep.
    for (int i = 0; i < 8; i++) write(0, i, 8'h10 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      nr8 = 3'(i);
      check(0, 8'h10 + 8'(i), $sformatf("sweep_r%0d", i));
    end

    // Asynchronous reset between edges while a write is pending.
    @(negedge clk);
    wr8 = 1'b1; nr8 = 3'd6; d8 = 8'h55;
    #1;
    rst = 1'b0;
    check(0, 8'h00, "async_rst_r6");
    @(posedge clk);
    #1;
    wr8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nr8 = 3'(i);
      check(0, 8'h00, $sformatf("post_rst_r%0d", i));
    end

    // Out-of-range on the 5-register bank.
    for (int i = 0; i < 5; i++) write(1, i, 8'h20 + 8'(i));
    @(negedge clk);
    wr5 = 1'b1; nr5 = 3'd6; d5 = 8'h77;
    check(1, 8'h00, "oor_pre_edge");
    @(posedge clk);
    #1;
    wr5 = 1'b0;
    check(1, 8'h00, "oor_r6");
    nr5 = 3'd7; check(1, 8'h00, "oor_r7");
    nr5 = 3'd5; check(1, 8'h00, "oor_r5");
    for (int i = 0; i < 5; i++) begin
      nr5 = 3'(i);
      check(1, 8'h20 + 8'(i), $sformatf("oor_keep_r%0d", i));
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 100 && sb_q.size() > 0; k++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t expected=finish", $time);
    $fatal(1, "watchdog");
  end

endmodule : tb_rejestry_bank
